// File: rtl/satatrn_txmux.sv
// satatrn_txmux: packet-atomic multiplexer of NCHAN FIS word streams onto one
// output stream. Stream DATA_CHAN carries data FISes: it is granted only while
// the synchronised txgate is high, and each of its packets is preceded by a
// generated 8'h46 header word.
// Ports:
//   i_phy_clk, i_phy_reset_n   clock, async active-low reset
//   i_txgate                   async permission to start a data FIS
//   i_valid/o_ready/i_data/i_last   per-stream inputs (stream k at [k*DW +: DW])
//   o_valid/i_ready/o_data/o_last/o_chan   registered output stream
//   o_busy                     packet in progress, incl. unaccepted final word
module satatrn_txmux #(
  parameter int unsigned NCHAN        = 2,
  parameter int unsigned DW           = 32,
  parameter int unsigned DATA_CHAN    = NCHAN - 1,
  parameter bit          OPT_RR       = 1'b1,
  parameter bit          OPT_LOWPOWER = 1'b0
) (
  input  logic                     i_phy_clk,
  input  logic                     i_phy_reset_n,
  input  logic                     i_txgate,
  input  logic [NCHAN-1:0]         i_valid,
  output logic [NCHAN-1:0]         o_ready,
  input  logic [NCHAN*DW-1:0]      i_data,
  input  logic [NCHAN-1:0]         i_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DW-1:0]            o_data,
  output logic                     o_last,
  output logic [$clog2(NCHAN)-1:0] o_chan,
  output logic                     o_busy
);

  localparam int unsigned   CW       = $clog2(NCHAN);
  localparam logic [CW-1:0] DCH      = CW'(DATA_CHAN);
  localparam logic [CW-1:0] G_RESET  = CW'(NCHAN - 1);
  localparam logic [DW-1:0] HDR_WORD = {8'h46, {(DW-8){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PKT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   g_q, g_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic            busy_q, busy_d;
  logic [1:0]      sync_q, sync_d;

  logic            txgate_s;
  logic            adv;
  logic [NCHAN-1:0] elig;
  logic [NCHAN-1:0] gate_mask;
  logic [NCHAN-1:0] ready_c;
  logic [CW-1:0]   pick;
  logic            found;
  int unsigned     idx;
  logic [DW-1:0]   data_a [NCHAN];

  // Unpack the flat input data bus into per-stream words
  for (genvar k = 0; k < NCHAN; k++) begin : g_unpack
    assign data_a[k] = i_data[k*DW +: DW];
  end

  // Two-flop synchroniser for the asynchronous txgate
  assign sync_d   = {sync_q[0], i_txgate};
  assign txgate_s = sync_q[1];

  assign adv       = !valid_q || i_ready;
  assign gate_mask = NCHAN'(!txgate_s) << DATA_CHAN;
  assign elig      = i_valid & ~gate_mask;

  // Grant selection: first eligible after the last grant, or lowest index
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    if (OPT_RR) begin
      for (int unsigned off = 1; off <= NCHAN; off++) begin
        idx = 32'(g_q) + off;
        if (idx >= NCHAN) idx = idx - NCHAN;
        if (!found && elig[CW'(idx)]) begin
          found = 1'b1;
          pick  = CW'(idx);
        end
      end
    end else begin
      // Descending scan so the lowest eligible index is assigned last
      for (int unsigned k = NCHAN; k > 0; k--) begin
        if (elig[CW'(k - 1)]) pick = CW'(k - 1);
      end
    end
  end

  // Arbiter next-state and output register inputs
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    chan_d  = chan_q;
    ready_c = '0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (adv) begin
          if (|elig) begin
            g_d     = pick;
            valid_d = 1'b1;
            chan_d  = pick;
            if (pick == DCH) begin
              // Header is generated locally; the stream's first word waits
              data_d  = HDR_WORD;
              last_d  = 1'b0;
              state_d = S_HDR;
            end else begin
              ready_c[pick] = 1'b1;
              data_d        = data_a[pick];
              last_d        = i_last[pick];
              state_d       = i_last[pick] ? S_IDLE : S_PKT;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      S_HDR, S_PKT: begin
        if (adv) begin
          ready_c[g_q] = 1'b1;
          if (i_valid[g_q]) begin
            valid_d = 1'b1;
            data_d  = data_a[g_q];
            last_d  = i_last[g_q];
            chan_d  = g_q;
            state_d = i_last[g_q] ? S_IDLE : S_PKT;
          end else begin
            // Source underrun: bubble the output but keep the packet open
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (OPT_LOWPOWER && !valid_d) begin
      data_d = '0;
      last_d = 1'b0;
      chan_d = '0;
    end

    busy_d = (state_d != S_IDLE) || valid_d;
  end

  // o_ready is combinational from state; force it low while reset is held
  assign o_ready = ready_c & {NCHAN{i_phy_reset_n}};

  // State and output registers
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
    if (!i_phy_reset_n) begin
      state_q <= S_IDLE;
      g_q     <= G_RESET;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      chan_q  <= '0;
      busy_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_chan  = chan_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_satatrn_txmux.sv
// Testbench for satatrn_txmux (NCHAN=2, DW=32, DATA_CHAN=1): directed packets
// with an expected-word queue checked by an independent output monitor, plus a
// fixed-priority low-power instance fed with two always-valid streams.
module tb_satatrn_txmux;

  localparam logic [31:0] HDR = 32'h4600_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        txgate;
  logic        i_ready;
  logic [1:0]  valid, last, o_ready;
  logic [63:0] data;
  logic        o_valid, o_last, o_chan, o_busy;
  logic [31:0] o_data;

  logic        fp_en, fp_rdy;
  logic [1:0]  fp_valid, fp_last, fp_o_ready, fp_fire;
  logic [63:0] fp_data;
  logic        fp_o_valid, fp_o_last, fp_o_chan, fp_o_busy;
  logic [31:0] fp_o_data;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q [$];
  logic [32:0] s0_q [$];
  logic [32:0] s1_q [$];
  logic [1:0]  fire;
  logic        prev_stall;
  logic [33:0] prev_w, cur_w, e_w;

  always #5 clk = ~clk;

  satatrn_txmux dut (
    .i_phy_clk(clk), .i_phy_reset_n(rst_n), .i_txgate(txgate),
    .i_valid(valid), .o_ready(o_ready), .i_data(data), .i_last(last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_chan(o_chan), .o_busy(o_busy)
  );

  satatrn_txmux #(.OPT_RR(1'b0), .OPT_LOWPOWER(1'b1)) dut_fp (
    .i_phy_clk(clk), .i_phy_reset_n(rst_n), .i_txgate(txgate),
    .i_valid(fp_valid), .o_ready(fp_o_ready), .i_data(fp_data), .i_last(fp_last),
    .o_valid(fp_o_valid), .i_ready(fp_rdy), .o_data(fp_o_data), .o_last(fp_o_last),
    .o_chan(fp_o_chan), .o_busy(fp_o_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic src(input int s, input logic [31:0] d, input logic l);
    if (s == 0) s0_q.push_back({l, d});
    else        s1_q.push_back({l, d});
  endtask

  task automatic expw(input logic c, input logic l, input logic [31:0] d);
    exp_q.push_back({c, l, d});
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Source driver: pops words accepted at the previous edge, drives the rest
  initial begin
    fire = '0; fp_fire = '0;
    valid = '0; last = '0; data = '0;
    fp_valid = '0; fp_last = '0;
    fp_data = {32'hBBBB_0001, 32'hAAAA_0000};
    forever begin
      @(negedge clk);
      if (!rst_n) fire = '0;
      if (fire[0] && s0_q.size() != 0) void'(s0_q.pop_front());
      if (fire[1] && s1_q.size() != 0) void'(s1_q.pop_front());
      valid[0] = (s0_q.size() != 0);
      valid[1] = (s1_q.size() != 0);
      if (valid[0]) {last[0], data[31:0]}  = s0_q[0];
      else          {last[0], data[31:0]}  = '0;
      if (valid[1]) {last[1], data[63:32]} = s1_q[0];
      else          {last[1], data[63:32]} = '0;
      if (fp_fire[0]) fp_last[0] = ~fp_last[0];
      if (fp_fire[1]) fp_last[1] = ~fp_last[1];
      fp_valid = {2{fp_en}};
      #1;
      fire    = valid & o_ready;
      fp_fire = fp_valid & fp_o_ready;
    end
  end

  // Output monitor: scoreboard pop on transfer, stall stability, grant sanity
  initial begin
    prev_stall = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        cur_w = {o_chan, o_last, o_data};
        if (prev_stall) begin
          chk("stall_valid", 64'(o_valid), 64'd1);
          chk("stall_word", 64'(cur_w), 64'(prev_w));
        end
        chk("ready_onehot0", 64'($onehot0(o_ready)), 64'd1);
        if (o_valid && !i_ready) chk("stall_ready", 64'(o_ready), 64'd0);
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h expected none (t=%0t)", cur_w, $time);
          end else begin
            e_w = exp_q.pop_front();
            chk("sb_word", 64'(cur_w), 64'(e_w));
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_w     = cur_w;
        if (fp_o_valid) chk("fp_chan", 64'(fp_o_chan), 64'd0);
        else chk("fp_lowpower", 64'({fp_o_last, fp_o_chan, fp_o_data}), 64'd0);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; txgate = 1'b0; i_ready = 1'b1; fp_en = 1'b0; fp_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy",  64'(o_busy),  64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_last",  64'(o_last),  64'd0);
    chk("rst_fp_data", 64'({fp_o_chan, fp_o_data}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Command stream 0 with txgate low: A,B,C back to back
    src(0, 32'hA000_000A, 1'b0); src(0, 32'hB000_000B, 1'b0); src(0, 32'hC000_000C, 1'b1);
    expw(1'b0, 1'b0, 32'hA000_000A); expw(1'b0, 1'b0, 32'hB000_000B); expw(1'b0, 1'b1, 32'hC000_000C);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("t1_valid", 64'(o_valid), 64'd1);
      chk("t1_last",  64'(o_last),  64'(i == 3));
      chk("t1_busy",  64'(o_busy),  64'd1);
    end
    @(posedge clk); #1;
    chk("t1_idle_valid", 64'(o_valid), 64'd0);
    chk("t1_idle_busy",  64'(o_busy),  64'd0);
    wait_drain(4);

    // Data stream 1: header precedes D0 and does not consume it
    txgate = 1'b1;
    repeat (3) tick();
    src(1, 32'hD000_0000, 1'b0); src(1, 32'hD000_0001, 1'b1);
    expw(1'b1, 1'b0, HDR); expw(1'b1, 1'b0, 32'hD000_0000); expw(1'b1, 1'b1, 32'hD000_0001);
    @(negedge clk); #2;
    chk("t2_hdr_noready", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    chk("t2_hdr_word", 64'({o_valid, o_chan, o_data}), 64'({1'b1, 1'b1, HDR}));
    chk("t2_data_ready", 64'(o_ready), 64'b10);
    wait_drain(8);

    // Round robin from last grant 1: 0,1,0,1; fixed-priority instance stays on 0
    fp_en = 1'b1;
    src(0, 32'h5000_0000, 1'b0); src(0, 32'h5000_0001, 1'b1);
    src(0, 32'h5000_0002, 1'b0); src(0, 32'h5000_0003, 1'b1);
    src(1, 32'h6000_0000, 1'b0); src(1, 32'h6000_0001, 1'b1);
    src(1, 32'h6000_0002, 1'b0); src(1, 32'h6000_0003, 1'b1);
    expw(1'b0, 1'b0, 32'h5000_0000); expw(1'b0, 1'b1, 32'h5000_0001);
    expw(1'b1, 1'b0, HDR); expw(1'b1, 1'b0, 32'h6000_0000); expw(1'b1, 1'b1, 32'h6000_0001);
    expw(1'b0, 1'b0, 32'h5000_0002); expw(1'b0, 1'b1, 32'h5000_0003);
    expw(1'b1, 1'b0, HDR); expw(1'b1, 1'b0, 32'h6000_0002); expw(1'b1, 1'b1, 32'h6000_0003);
    wait_drain(20);
    fp_en = 1'b0;

    // Output stall for 4 cycles mid-packet
    src(0, 32'hE000_0000, 1'b0); src(0, 32'hE000_0001, 1'b0);
    src(0, 32'hE000_0002, 1'b0); src(0, 32'hE000_0003, 1'b1);
    expw(1'b0, 1'b0, 32'hE000_0000); expw(1'b0, 1'b0, 32'hE000_0001);
    expw(1'b0, 1'b0, 32'hE000_0002); expw(1'b0, 1'b1, 32'hE000_0003);
    tick();
    i_ready = 1'b0;
    repeat (4) tick();
    i_ready = 1'b1;
    wait_drain(10);

    // Source underrun mid-packet: bubble, packet stays open
    src(0, 32'hF000_0000, 1'b0);
    expw(1'b0, 1'b0, 32'hF000_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_valid", 64'(o_valid), 64'd0);
    chk("gap_busy",  64'(o_busy),  64'd1);
    #2;
    src(0, 32'hF000_0001, 1'b1);
    expw(1'b0, 1'b1, 32'hF000_0001);
    wait_drain(6);

    // txgate drop during a data packet does not cut it short
    src(1, 32'h7000_0000, 1'b0); src(1, 32'h7000_0001, 1'b0);
    src(1, 32'h7000_0002, 1'b0); src(1, 32'h7000_0003, 1'b1);
    expw(1'b1, 1'b0, HDR); expw(1'b1, 1'b0, 32'h7000_0000); expw(1'b1, 1'b0, 32'h7000_0001);
    expw(1'b1, 1'b0, 32'h7000_0002); expw(1'b1, 1'b1, 32'h7000_0003);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_valid && n < 10);
    chk("t5_start", 64'(o_valid), 64'd1);
    txgate = 1'b0;
    wait_drain(12);
    src(1, 32'h8000_0000, 1'b1);
    expw(1'b1, 1'b0, HDR); expw(1'b1, 1'b1, 32'h8000_0000);
    repeat (6) begin
      @(posedge clk); #1;
      chk("t5_gated", 64'(o_valid), 64'd0);
    end
    #2;
    txgate = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_valid && n < 8);
    chk("t5_gate_latency", 64'(n), 64'd3);
    #2;
    wait_drain(6);

    // Reset mid-packet discards it; next packet starts cleanly
    src(0, 32'h9000_0000, 1'b0); src(0, 32'h9000_0001, 1'b0);
    src(0, 32'h9000_0002, 1'b0); src(0, 32'h9000_0003, 1'b1);
    expw(1'b0, 1'b0, 32'h9000_0000); expw(1'b0, 1'b0, 32'h9000_0001);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(o_valid), 64'd0);
    chk("t6_rst_busy",  64'(o_busy),  64'd0);
    chk("t6_rst_ready", 64'(o_ready), 64'd0);
    s0_q.delete(); s1_q.delete(); exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    src(0, 32'h9100_0000, 1'b0); src(0, 32'h9100_0001, 1'b1);
    expw(1'b0, 1'b0, 32'h9100_0000); expw(1'b0, 1'b1, 32'h9100_0001);
    @(posedge clk); #1;
    chk("t6_first_word", 64'({o_valid, o_data}), 64'({1'b1, 32'h9100_0000}));
    #2;
    wait_drain(6);
    tick();
    chk("end_busy", 64'(o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
